// File: rtl/serial_nibble_adder_pkg.sv
// Shared definitions for the serial nibble adder.
//   - state_t  : controller states (IDLE, RUN, DONE)
//   - NIBBLE_W : width of the ripple adder slice, in bits
package serial_nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_nibble_adder_slice.sv
// Purely combinational 4-bit dataflow ripple-carry adder.
// Ports:
//   a, b      : nibble operands
//   carry_in  : carry into bit 0
//   sum       : nibble sum
//   carry_out : carry out of bit 3
module serial_nibble_adder_slice
  import serial_nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out
);

  logic [NIBBLE_W:0] c;

  assign c[0] = carry_in;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carry_out = c[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per clock through a
// single 4-bit ripple slice, keeping the inter-nibble carry in a register.
// WIDTH must be a multiple of 4 and at least 4.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   start         : operation request, sampled only while idle
//   a, b          : operands, captured when start is accepted
//   carry_in      : carry into nibble 0, captured with the operands
//   busy          : high while nibbles are being processed
//   done          : one-cycle completion pulse
//   sum           : result, held until the next completion
//   carry_out     : carry out of the top nibble, held with sum
module serial_nibble_adder
  import serial_nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   partial_q, partial_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_q, c_d;
  logic               carry_out_q, carry_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NIBBLE_W-1:0] s_nib;
  logic                c_nxt;

  // The slice always sees the lowest nibble of the shifted operands.
  serial_nibble_adder_slice u_slice (
    .a         (a_sh_q[NIBBLE_W-1:0]),
    .b         (b_sh_q[NIBBLE_W-1:0]),
    .carry_in  (c_q),
    .sum       (s_nib),
    .carry_out (c_nxt)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    partial_d   = partial_q;
    sum_d       = sum_q;
    c_d         = c_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = carry_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sh_d = a_sh_q >> NIBBLE_W;
        b_sh_d = b_sh_q >> NIBBLE_W;
        // New nibble enters at the top so that after NIB steps the
        // register holds the full sum in natural bit order. Written as
        // shifts so the WIDTH=4 case needs no empty part-select.
        partial_d = (partial_q >> NIBBLE_W) | (WIDTH'(s_nib) << (WIDTH - NIBBLE_W));
        c_d       = c_nxt;
        if (cnt_q == CNT_W'(NIB - 1)) begin
          sum_d       = partial_d;
          carry_out_d = c_nxt;
          // Cleared rather than incremented so the count never wraps.
          cnt_d       = '0;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      partial_q   <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      partial_q   <= partial_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule
